trng_gen: RTL and testbench
===========================

TRNG_GEN -- requirements
Module: trng_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: output word width, 2..32.
REQ-002 SHALL have parameter LFSR_LEN, default 16: conditioning LFSR length, >= WIDTH.
REQ-003 SHALL have parameter LFSR_TAPS, default 16'hB400: feedback tap mask, LFSR_LEN bits.
REQ-004 SHALL have parameter LFSR_SEED, default 1: LFSR reset value, nonzero.
REQ-005 SHALL have parameter RO_SEED, default 3'b001: ring-model reset value, nonzero.
REQ-006 SHALL have parameter REP_LIMIT, default 8: identical-sample run that trips the health test, >= 2.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port en, input, 1: generation enable.
REQ-010 SHALL have port mode, input, 1: 0 = LFSR-conditioned, 1 = von Neumann whitened.
REQ-011 SHALL have port ext_ent_en, input, 1: 1 selects ext_ent as the entropy sample.
REQ-012 SHALL have port ext_ent, input, 1: injected entropy bit.
REQ-013 SHALL have port rand_out, output, WIDTH: word held in the output buffer.
REQ-014 SHALL have port rand_valid, output, 1: rand_out holds an unconsumed word.
REQ-015 SHALL have port rand_ready, input, 1: consumer accepts; transfer when rand_valid & rand_ready.
REQ-016 SHALL have port health_fail, output, 1: sticky health-test failure.

Function
REQ-017 SHALL keep a 3-bit ring model ro running every cycle: ro <= {ro[1:0], ro[2]^ro[1]}.
REQ-018 SHALL sample entropy e = ext_ent_en ? ext_ent : ro[0] every cycle, regardless of en.
REQ-019 SHALL, in mode 0, produce one bit per COLLECT cycle: b = e ^ ^(lfsr & LFSR_TAPS); lfsr <= {lfsr[LFSR_LEN-2:0], b}.
REQ-020 SHALL, in mode 1, pair consecutive COLLECT-cycle samples: 01 -> 0, 10 -> 1, 00/11 -> nothing; lfsr holds; the pair phase clears on leaving COLLECT or a mode change.
REQ-021 SHALL shift each produced bit into the collector LSB, shifting left, so the first bit becomes the MSB.
REQ-022 SHALL count bits 0..WIDTH-1; on the WIDTH-th bit the word moves to the output buffer in the same edge if the buffer is empty or being consumed, else to STALL.
REQ-023 SHALL implement FSM IDLE, COLLECT, STALL, FAIL: IDLE->COLLECT when en; COLLECT->IDLE when !en, keeping the partial word and count; COLLECT->STALL when a full word is blocked; STALL->COLLECT when the buffer frees, loading the held word at that edge; any->FAIL on health trip.
REQ-024 SHALL give first-word latency in mode 0: rand_valid high WIDTH+1 cycles after en rises from reset.
REQ-025 SHALL hold rand_out stable while rand_valid & !rand_ready; simultaneous consume and load leaves rand_valid high with the new word.
REQ-026 SHALL run a repetition test on e every cycle: run counter resets to 1 on change and saturates at REP_LIMIT; health_fail is set the cycle after the REP_LIMIT-th identical sample.
REQ-027 SHALL, in FAIL, force rand_valid=0, discard buffered and partial words, and stay in FAIL until reset.

Reset
REQ-028 SHALL, on reset, asynchronously set rand_out=0, rand_valid=0, health_fail=0, state=IDLE, count=0, collector=0, lfsr=LFSR_SEED, ro=RO_SEED, run counter=1.
REQ-029 SHALL, on reset mid-word or in STALL, discard all pending data with no partial output.

Structure
REQ-030 SHALL place the FSM state enum and mode encoding in package trng_pkg.
REQ-031 SHALL implement the ring model, entropy mux and repetition test in sub-module trng_health_src; everything else stays in trng_gen.

Verification
REQ-032 SHALL verify reset: with reset asserted mid-COLLECT, all outputs return to REQ-028 values without a clock edge.
REQ-033 SHALL verify whitening: WIDTH=8, mode=1, ext_ent_en=1, ext_ent repeating 0,1,1,0, rand_ready=1 -> rand_out=8'h55 every 16 cycles.
REQ-034 SHALL verify backpressure: REQ-033 stimulus with rand_ready=0 -> STALL after the second word; ready then high gives 8'h55 twice, no loss or duplication.
REQ-035 SHALL verify health: REP_LIMIT=4, ext_ent held 1 for 4 cycles -> health_fail=1 next cycle, rand_valid=0 until reset.
REQ-036 SHALL verify mode 0 against a bit-accurate LFSR model for 1000 words, first valid at cycle WIDTH+1 after en.
REQ-037 SHALL verify en drop at bit 5 of 8 then re-raise -> word completes after 3 more COLLECT cycles, no corruption.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types for the TRNG generator: FSM states and conditioning mode encoding.
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_STALL   = 2'd2,
    ST_FAIL    = 2'd3
  } state_e;

  typedef enum logic {
    MODE_LFSR = 1'b0,
    MODE_VN   = 1'b1
  } mode_e;

endpackage

// File: rtl/trng_health_src.sv
// Entropy source: 3-bit ring model, entropy select and repetition-count health test.
module trng_health_src #(
  parameter logic [2:0] RO_SEED   = 3'b001,
  parameter int         REP_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ext_ent_en,
  input  logic ext_ent,
  output logic ent,
  output logic trip
);

  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [2:0]    ro_q, ro_d;
  logic          last_q, last_d;
  logic [RW-1:0] run_q, run_d;

  always_comb begin
    ro_d   = {ro_q[1:0], ro_q[2] ^ ro_q[1]};
    ent    = ext_ent_en ? ext_ent : ro_q[0];
    last_d = ent;
    if (ent != last_q)
      run_d = RW'(1);
    else if (run_q == RW'(REP_LIMIT))
      run_d = run_q;
    else
      run_d = run_q + RW'(1);
    // Trip as the REP_LIMIT-th identical sample is registered; the flag lands next cycle.
    trip = (run_d == RW'(REP_LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ro_q   <= RO_SEED;
      last_q <= 1'b0;
      run_q  <= RW'(1);
    end else begin
      ro_q   <= ro_d;
      last_q <= last_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/trng_gen.sv
// TRNG word generator: LFSR-conditioned or von Neumann whitened bits packed into
// WIDTH-bit words behind a one-entry valid/ready output buffer.
//
// state   | meaning
// IDLE    | not collecting; partial word and count retained
// COLLECT | one entropy sample per cycle while en is high
// STALL   | full word held, waiting for the output buffer to free
// FAIL    | health test tripped; output suppressed until reset
module trng_gen
  import trng_pkg::*;
#(
  parameter int                  WIDTH     = 8,
  parameter int                  LFSR_LEN  = 16,
  parameter logic [LFSR_LEN-1:0] LFSR_TAPS = LFSR_LEN'(16'hB400),
  parameter logic [LFSR_LEN-1:0] LFSR_SEED = LFSR_LEN'(1),
  parameter logic [2:0]          RO_SEED   = 3'b001,
  parameter int                  REP_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             ext_ent_en,
  input  logic             ext_ent,
  output logic [WIDTH-1:0] rand_out,
  output logic             rand_valid,
  input  logic             rand_ready,
  output logic             health_fail
);

  localparam int CW = $clog2(WIDTH);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    col_q, col_d;
  logic [LFSR_LEN-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                valid_q, valid_d;
  logic                fail_q, fail_d;
  logic                vn_have_q, vn_have_d;
  logic                vn_first_q, vn_first_d;

  logic             ent, trip;
  logic             collect, lfsr_fb, bit_vld, bit_val, word_done, buf_free;
  logic [WIDTH-1:0] col_shift;

  trng_health_src #(
    .RO_SEED  (RO_SEED),
    .REP_LIMIT(REP_LIMIT)
  ) u_src (
    .clk       (clk),
    .reset     (reset),
    .ext_ent_en(ext_ent_en),
    .ext_ent   (ext_ent),
    .ent       (ent),
    .trip      (trip)
  );

  always_comb begin
    collect = (state_q == ST_COLLECT) && en && !trip;
    lfsr_fb = ent ^ (^(lfsr_q & LFSR_TAPS));
    bit_vld = 1'b0;
    bit_val = 1'b0;
    if (collect) begin
      if (mode_e'(mode) == MODE_LFSR) begin
        bit_vld = 1'b1;
        bit_val = lfsr_fb;
      end else if (vn_have_q && (vn_first_q != ent)) begin
        bit_vld = 1'b1;
        bit_val = vn_first_q;
      end
    end
    word_done = bit_vld && (cnt_q == CW'(WIDTH - 1));
    buf_free  = !valid_q || rand_ready;
    col_shift = {col_q[WIDTH-2:0], bit_val};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (en) state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (!en)
          state_d = ST_IDLE;
        else if (word_done && !buf_free)
          state_d = ST_STALL;
      end
      ST_STALL:   if (buf_free) state_d = ST_COLLECT;
      ST_FAIL:    state_d = ST_FAIL;
      default:    state_d = ST_IDLE;
    endcase
    if (trip) state_d = ST_FAIL;
  end

  always_comb begin
    lfsr_d     = lfsr_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    valid_d    = valid_q;
    fail_d     = fail_q;
    vn_have_d  = 1'b0;
    vn_first_d = vn_first_q;

    if (valid_q && rand_ready) valid_d = 1'b0;

    if (collect) begin
      if (mode_e'(mode) == MODE_LFSR) begin
        lfsr_d = {lfsr_q[LFSR_LEN-2:0], lfsr_fb};
      end else if (!vn_have_q) begin
        vn_have_d  = 1'b1;
        vn_first_d = ent;
      end
      if (bit_vld) begin
        col_d = col_shift;
        cnt_d = cnt_q + CW'(1);
        if (word_done) begin
          cnt_d = '0;
          if (buf_free) begin
            out_d   = col_shift;
            valid_d = 1'b1;
            col_d   = '0;
          end
        end
      end
    end

    if ((state_q == ST_STALL) && buf_free) begin
      out_d   = col_q;
      valid_d = 1'b1;
      col_d   = '0;
    end

    if (trip || (state_q == ST_FAIL)) begin
      fail_d    = 1'b1;
      valid_d   = 1'b0;
      out_d     = '0;
      col_d     = '0;
      cnt_d     = '0;
      vn_have_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      col_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      out_q      <= '0;
      valid_q    <= 1'b0;
      fail_q     <= 1'b0;
      vn_have_q  <= 1'b0;
      vn_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      lfsr_q     <= lfsr_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      fail_q     <= fail_d;
      vn_have_q  <= vn_have_d;
      vn_first_q <= vn_first_d;
    end
  end

  assign rand_out    = out_q;
  assign rand_valid  = valid_q;
  assign health_fail = fail_q;

endmodule

// File: tb/tb_trng_gen.sv
// Scoreboard bench for trng_gen: stimulus pushes expected words, a negedge monitor pops on transfer.
module tb_trng_gen;
  import trng_pkg::*;

  localparam logic [15:0] TAPS = 16'hB400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, mode = 1'b0, ext_ent_en = 1'b0, ext_ent = 1'b0, rand_ready = 1'b0;
  logic [7:0] rand_out, h_out;
  logic       rand_valid, health_fail, h_valid, h_fail;

  trng_gen #(.WIDTH(8), .REP_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .ext_ent_en(ext_ent_en),
    .ext_ent(ext_ent), .rand_out(rand_out), .rand_valid(rand_valid),
    .rand_ready(rand_ready), .health_fail(health_fail)
  );

  trng_gen #(.WIDTH(8), .REP_LIMIT(4)) hdut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .ext_ent_en(ext_ent_en),
    .ext_ent(ext_ent), .rand_out(h_out), .rand_valid(h_valid),
    .rand_ready(rand_ready), .health_fail(h_fail)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int xfers = 0;
  bit mon_on = 1'b0;
  bit use_model = 1'b0;
  logic [7:0] exp_q[$];
  int xfer_t[$];

  logic [2:0]  ro_m;
  logic [15:0] lfsr_m;
  logic [7:0]  col_m;
  int          cnt_m;
  bit          st_m;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && !reset && rand_valid && rand_ready) begin
      xfers++;
      xfer_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word act=%0h exp=none", rand_out);
      end else begin
        chk("word", {24'd0, rand_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic pat(input int k);
    return (k % 4 == 1) || (k % 4 == 2);
  endfunction

  // One clock cycle: drive inputs, advance the spec-level model, wait past the edge.
  task automatic tick(input logic en_v, input logic mode_v, input logic xen_v,
                      input logic x_v, input logic rdy_v);
    logic e, b;
    en = en_v; mode = mode_v; ext_ent_en = xen_v; ext_ent = x_v; rand_ready = rdy_v;
    e = xen_v ? x_v : ro_m[0];
    if (use_model && st_m && en_v && !mode_v) begin
      b = e ^ (^(lfsr_m & TAPS));
      lfsr_m = {lfsr_m[14:0], b};
      col_m = {col_m[6:0], b};
      cnt_m++;
      if (cnt_m == 8) begin
        exp_q.push_back(col_m);
        cnt_m = 0;
      end
    end
    st_m = en_v;
    ro_m = {ro_m[1:0], ro_m[2] ^ ro_m[1]};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0; mode = 1'b0; ext_ent_en = 1'b0; ext_ent = 1'b0; rand_ready = 1'b0;
    exp_q.delete();
    xfer_t.delete();
    xfers = 0;
    ro_m = 3'b001; lfsr_m = 16'h0001; col_m = '0; cnt_m = 0; st_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    do_reset();
    chk("rst_out", {24'd0, rand_out}, 32'd0);
    chk("rst_valid", {31'd0, rand_valid}, 32'd0);
    chk("rst_hf", {31'd0, health_fail}, 32'd0);

    // Whitening: 0,1,1,0 -> 8'h55 every 16 cycles
    do_reset();
    mon_on = 1'b1;
    repeat (4) exp_q.push_back(8'h55);
    tick(1, 1, 1, 0, 1);
    for (int k = 0; k < 64; k++) tick(1, 1, 1, pat(k), 1);
    tick(0, 1, 1, 0, 1);
    chk("vn_xfers", xfers, 32'd4);
    chk("vn_drain", exp_q.size(), 32'd0);
    for (int i = 1; i < xfer_t.size(); i++)
      chk("vn_period", xfer_t[i] - xfer_t[i-1], 32'd16);

    // Backpressure: second word stalls, then two words drain in order
    do_reset();
    repeat (2) exp_q.push_back(8'h55);
    tick(1, 1, 1, 0, 0);
    for (int k = 0; k < 32; k++) tick(1, 1, 1, pat(k), 0);
    chk("bp_stall", 32'(dut.state_q), 32'(ST_STALL));
    chk("bp_valid", {31'd0, rand_valid}, 32'd1);
    chk("bp_out", {24'd0, rand_out}, 32'h55);
    repeat (3) tick(0, 1, 1, 0, 0);
    chk("bp_hold_state", 32'(dut.state_q), 32'(ST_STALL));
    chk("bp_hold_out", {24'd0, rand_out}, 32'h55);
    repeat (4) tick(0, 1, 1, 0, 1);
    chk("bp_xfers", xfers, 32'd2);
    chk("bp_drain", exp_q.size(), 32'd0);
    chk("bp_idle_valid", {31'd0, rand_valid}, 32'd0);

    // Reset mid-COLLECT with a word buffered
    do_reset();
    tick(1, 1, 1, 0, 0);
    for (int k = 0; k < 20; k++) tick(1, 1, 1, pat(k), 0);
    chk("mid_valid", {31'd0, rand_valid}, 32'd1);
    chk("mid_out", {24'd0, rand_out}, 32'h55);
    reset = 1'b1;
    #2;
    chk("async_out", {24'd0, rand_out}, 32'd0);
    chk("async_valid", {31'd0, rand_valid}, 32'd0);
    chk("async_hf", {31'd0, health_fail}, 32'd0);
    chk("async_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("async_col", {24'd0, dut.col_q}, 32'd0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 1, pat(k), 1);
      chk("post_rst_valid", {31'd0, rand_valid}, 32'd0);
    end

    // Mode 0 latency and 1000 words against the LFSR model
    do_reset();
    use_model = 1'b1;
    repeat (8) tick(1, 0, 0, 0, 1);
    chk("lat_before", {31'd0, rand_valid}, 32'd0);
    tick(1, 0, 0, 0, 1);
    chk("lat_at", {31'd0, rand_valid}, 32'd1);
    repeat (8 * 999) tick(1, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    chk("m0_xfers", xfers, 32'd1000);
    chk("m0_drain", exp_q.size(), 32'd0);

    // en drop after 5 bits, re-raise, 3 more bits complete the word
    do_reset();
    tick(1, 0, 0, 0, 1);
    repeat (5) tick(1, 0, 0, 0, 1);
    repeat (3) tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    repeat (2) tick(1, 0, 0, 0, 1);
    chk("drop_early", {31'd0, rand_valid}, 32'd0);
    tick(1, 0, 0, 0, 1);
    chk("drop_done", {31'd0, rand_valid}, 32'd1);
    tick(0, 0, 0, 0, 1);
    chk("drop_xfers", xfers, 32'd1);
    chk("drop_drain", exp_q.size(), 32'd0);
    use_model = 1'b0;

    // Health: REP_LIMIT=4 instance trips after 4 ones, REP_LIMIT=8 after 8
    mon_on = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) tick(1, 0, 1, i[0], 0);
    chk("h_pre_valid", {31'd0, h_valid}, 32'd1);
    tick(1, 0, 1, 0, 0);
    repeat (3) tick(1, 0, 1, 1, 0);
    chk("h_three", {31'd0, h_fail}, 32'd0);
    tick(1, 0, 1, 1, 0);
    chk("h_four", {31'd0, h_fail}, 32'd1);
    chk("h_valid_drop", {31'd0, h_valid}, 32'd0);
    chk("m_four", {31'd0, health_fail}, 32'd0);
    repeat (3) tick(1, 0, 1, 1, 0);
    chk("m_seven", {31'd0, health_fail}, 32'd0);
    tick(1, 0, 1, 1, 0);
    chk("m_eight", {31'd0, health_fail}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 1, i[0], 1);
      chk("h_sticky_valid", {31'd0, h_valid}, 32'd0);
    end
    chk("h_sticky", {31'd0, h_fail}, 32'd1);
    chk("h_state", 32'(hdut.state_q), 32'(ST_FAIL));
    do_reset();
    chk("h_cleared", {31'd0, h_fail}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
